mole_scheduler: RTL and testbench

//  Game sequencer for whack-a-mole. Picks a pseudo-random mole index (1..7) and drives it

---
 rtl/mole_scheduler.sv | 153 +++++++++++++++
 tb/tb_mole_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: spawns pseudo-random moles, times the up/gap windows,
// scores edge-detected button presses against the lit LED, and counts rounds.
module mole_scheduler #(
   parameter int unsigned UP_TICKS  = 25_000_000,
   parameter int unsigned GAP_TICKS = 12_500_000,
   parameter int unsigned ROUNDS    = 20,
   parameter logic [2:0]  LFSR_SEED = 3'b001
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [4:0] btn,
   output logic [2:0] number,
   output logic       mole_active,
   output logic [7:0] score,
   output logic [7:0] misses,
   output logic [7:0] round_cnt,
   output logic       game_over
);

   localparam int unsigned MAX_TICKS = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
   localparam int unsigned TW        = $clog2(MAX_TICKS);
   localparam logic [TW-1:0] UP_LAST  = TW'(UP_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
   localparam logic [7:0]    ROUNDS_B = 8'(ROUNDS);
   // An all-zero seed would lock the LFSR, so it is replaced by 001.
   localparam logic [2:0]    SEED     = (LFSR_SEED == 3'b000) ? 3'b001 : LFSR_SEED;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPAWN,
      S_UP,
      S_HIT,
      S_MISS,
      S_GAP,
      S_DONE
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [2:0]      lfsr;
   logic [4:0]      btn_q;
   logic [4:0]      press;
   logic [4:0]      mask;
   logic            wrong_press;
   logic            right_press;

   // Must stay identical to the LED decoder's index-to-LED mapping.
   function automatic logic [4:0] led_mask(input logic [2:0] idx);
      case (idx)
         3'd1:    return 5'b00001;
         3'd2:    return 5'b01000;
         3'd3:    return 5'b00010;
         3'd4:    return 5'b00100;
         3'd5:    return 5'b10000;
         3'd6:    return 5'b01000;
         3'd7:    return 5'b00001;
         default: return 5'b00000;
      endcase
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      press       = btn & ~btn_q;
      mask        = led_mask(number);
      wrong_press = |(press & ~mask);
      right_press = |(press & mask);
   end

   // NOTE: every register here is assigned with <= so all state updates see the
   // pre-edge values; mixing in = would make the result depend on statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         number      <= 3'd0;
         mole_active <= 1'b0;
         score       <= 8'd0;
         misses      <= 8'd0;
         round_cnt   <= 8'd0;
         game_over   <= 1'b0;
         btn_q       <= 5'd0;
         lfsr        <= SEED;
         timer       <= '0;
      end else begin
         btn_q <= btn;
         case (state)
            S_IDLE: begin
               if (start) begin
                  score     <= 8'd0;
                  misses    <= 8'd0;
                  round_cnt <= 8'd0;
                  state     <= S_SPAWN;
               end
            end
            S_SPAWN: begin
               number      <= lfsr;
               mole_active <= 1'b1;
               lfsr        <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
               timer       <= '0;
               state       <= S_UP;
            end
            S_UP: begin
               timer <= timer + 1'b1;
               // A wrong button outranks a simultaneous right one.
               if (wrong_press)         state <= S_MISS;
               else if (right_press)    state <= S_HIT;
               else if (timer == UP_LAST) state <= S_MISS;
            end
            S_HIT: begin
               score       <= sat_inc(score);
               number      <= 3'd0;
               mole_active <= 1'b0;
               round_cnt   <= round_cnt + 8'd1;
               timer       <= '0;
               state       <= S_GAP;
            end
            S_MISS: begin
               misses      <= sat_inc(misses);
               number      <= 3'd0;
               mole_active <= 1'b0;
               round_cnt   <= round_cnt + 8'd1;
               timer       <= '0;
               state       <= S_GAP;
            end
            S_GAP: begin
               timer <= timer + 1'b1;
               if (timer == GAP_LAST) begin
                  if (round_cnt == ROUNDS_B) begin
                     game_over <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     state <= S_SPAWN;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  score     <= 8'd0;
                  misses    <= 8'd0;
                  round_cnt <= 8'd0;
                  game_over <= 1'b0;
                  state     <= S_SPAWN;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: directed vector table for the first game,
// hand-written DONE/reset sequences, then randomized games against a round-level model.
`timescale 1ns/1ps
module tb_mole_scheduler;

   localparam int UP  = 8;
   localparam int GAP = 4;
   localparam int RND = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [4:0] btn;
   logic [2:0] number;
   logic       mole_active;
   logic [7:0] score;
   logic [7:0] misses;
   logic [7:0] round_cnt;
   logic       game_over;

   always #5 clk = ~clk;

   mole_scheduler #(
      .UP_TICKS (UP),
      .GAP_TICKS(GAP),
      .ROUNDS   (RND),
      .LFSR_SEED(3'b001)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .btn        (btn),
      .number     (number),
      .mole_active(mole_active),
      .score      (score),
      .misses     (misses),
      .round_cnt  (round_cnt),
      .game_over  (game_over)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Round-level reference model: mole order from the documented LFSR sequence.
   int seq[7]     = '{1, 2, 5, 3, 7, 6, 4};
   int mask_of[8] = '{0, 1, 8, 2, 4, 16, 8, 1};
   int seq_idx;
   int m_score;
   int m_misses;
   int m_round;

   function automatic void model_start();
      m_score  = 0;
      m_misses = 0;
      m_round  = 0;
   endfunction

   function automatic int next_number();
      int v;
      v       = seq[seq_idx];
      seq_idx = (seq_idx + 1) % 7;
      return v;
   endfunction

   function automatic void model_result(input bit hit);
      m_round++;
      if (hit) m_score  = (m_score  < 255) ? m_score + 1  : 255;
      else     m_misses = (m_misses < 255) ? m_misses + 1 : 255;
   endfunction

   function automatic int pick_wrong(input int mask);
      int b;
      do b = $urandom_range(0, 4); while (((mask >> b) & 1) != 0);
      return 1 << b;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_mole(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (mole_active) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) check("mole_rise_timeout", 0, 1);
   endtask

   task automatic check_counters(input string tag, input int s, input int m, input int r);
      check({tag, "_score"}, score, s);
      check({tag, "_misses"}, misses, m);
      check({tag, "_round"}, round_cnt, r);
   endtask

   // One mole: held patterns or no press must time out; otherwise press after delay.
   task automatic run_round(input string tag, input logic [4:0] pat, input int delay,
                            input bit hold, input int exp_num, input int exp_s,
                            input int exp_m, input int exp_r);
      bit ok;
      int highs;
      if (hold) btn = pat;
      wait_mole(ok);
      if (!ok) return;
      check({tag, "_number"}, number, exp_num);
      if (!hold && pat != 5'd0) begin
         repeat (delay) tick();
         btn = pat;
         tick();
         btn = 5'd0;
         check({tag, "_lat_active"}, mole_active, 1);
         check({tag, "_lat_round"}, round_cnt, exp_r - 1);
         tick();
         check({tag, "_lat_number"}, number, 0);
         check({tag, "_lat_off"}, mole_active, 0);
      end else begin
         highs = 0;
         while (mole_active && highs < 64) begin
            highs++;
            tick();
         end
         check({tag, "_timeout_len"}, highs, UP + 1);
         btn = 5'd0;
      end
      check_counters(tag, exp_s, exp_m, exp_r);
   endtask

   task automatic wait_done(input string tag, output int cnt);
      cnt = 0;
      while (!game_over && cnt < 64) begin
         tick();
         cnt++;
      end
      check({tag, "_game_over"}, game_over, 1);
   endtask

   typedef struct {
      logic [4:0] pat;
      int         delay;
      bit         hold;
      int         exp_num;
      int         exp_score;
      int         exp_misses;
      int         exp_round;
   } vec_t;

   vec_t vecs[3];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int cnt;
      bit ok;
      int num;

      vecs[0] = '{5'b00001, 0, 1'b0, 1, 1, 0, 1};  // right button hit
      vecs[1] = '{5'b01000, 0, 1'b1, 2, 1, 1, 2};  // held button, timeout
      vecs[2] = '{5'b10001, 3, 1'b0, 5, 1, 2, 3};  // wrong + right together

      reset_n = 1'b0;
      start   = 1'b0;
      btn     = 5'd0;
      seq_idx = 0;
      model_start();
      #12;
      check("rst_number", number, 0);
      check("rst_active", mole_active, 0);
      check("rst_game_over", game_over, 0);
      check_counters("rst", 0, 0, 0);
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      check("idle_no_mole", mole_active, 0);

      // Directed first game from the vector table.
      pulse_start();
      for (int i = 0; i < 3; i++)
         run_round($sformatf("vec%0d", i), vecs[i].pat, vecs[i].delay, vecs[i].hold,
                   vecs[i].exp_num, vecs[i].exp_score, vecs[i].exp_misses, vecs[i].exp_round);
      wait_done("g1", cnt);
      check("g1_done_delay", cnt, GAP);
      repeat (5) tick();
      check("g1_hold_over", game_over, 1);
      check_counters("g1_hold", 1, 2, 3);
      seq_idx = 3;

      // Restart from DONE: counters clear and the LFSR continues.
      pulse_start();
      model_start();
      check("g2_start_over", game_over, 0);
      check_counters("g2_start", 0, 0, 0);
      num = next_number();
      model_result(1'b1);
      run_round("g2r1", 5'(mask_of[num]), 1, 1'b0, num, m_score, m_misses, m_round);

      // Asynchronous reset in the middle of an up-window.
      num = next_number();
      wait_mole(ok);
      check("g2r2_number", number, num);
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_number", number, 0);
      check("mid_rst_active", mole_active, 0);
      check("mid_rst_game_over", game_over, 0);
      check_counters("mid_rst", 0, 0, 0);
      tick();
      reset_n = 1'b1;
      seq_idx = 0;
      tick();

      // Randomized games against the model.
      for (int g = 0; g < 8; g++) begin
         pulse_start();
         model_start();
         for (int r = 0; r < RND; r++) begin
            int act;
            int mask;
            logic [4:0] pat;
            bit hold;
            bit hit;
            num  = next_number();
            mask = mask_of[num];
            act  = $urandom_range(0, 4);
            hold = 1'b0;
            hit  = 1'b0;
            case (act)
               0: pat = 5'd0;
               1: begin pat = 5'(mask); hit = 1'b1; end
               2: pat = 5'(pick_wrong(mask));
               3: pat = 5'(mask | pick_wrong(mask));
               default: begin pat = 5'($urandom_range(1, 31)); hold = 1'b1; end
            endcase
            model_result(hit);
            run_round($sformatf("rg%0dr%0d", g, r), pat, $urandom_range(0, UP - 1), hold,
                      num, m_score, m_misses, m_round);
            if ($urandom_range(0, 1) == 1) begin
               btn = 5'($urandom_range(1, 31));
               tick();
               btn   = 5'd0;
               start = 1'b1;
               tick();
               start = 1'b0;
               check_counters($sformatf("rg%0dr%0d_gap", g, r), m_score, m_misses, m_round);
            end
         end
         wait_done($sformatf("rg%0d", g), cnt);
         check("rg_done_number", number, 0);
         check_counters($sformatf("rg%0d_done", g), m_score, m_misses, m_round);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
